// File: rtl/ncpu32k_bpu_bimodal_if.sv
// Lookup and training bus between the fetch-side PC generator, the branch unit and the BPU.
// The master side is the pipeline; the slave side is the predictor.
interface ncpu32k_bpu_bimodal_if #(
    parameter int AW = 30
);
    logic          bpu_flush;
    logic          bpu_ready;
    logic          bpu_req;
    logic [AW-1:0] bpu_insn_pc;
    logic          bpu_pred_valid;
    logic          bpu_pred_taken;
    logic [AW-1:0] bpu_pred_tgt;
    logic          bpu_wb;
    logic [AW-1:0] bpu_wb_insn_pc;
    logic          bpu_wb_taken;
    logic [AW-1:0] bpu_wb_tgt;

    modport master (
        output bpu_flush, bpu_req, bpu_insn_pc,
        output bpu_wb, bpu_wb_insn_pc, bpu_wb_taken, bpu_wb_tgt,
        input  bpu_ready, bpu_pred_valid, bpu_pred_taken, bpu_pred_tgt
    );

    modport slave (
        input  bpu_flush, bpu_req, bpu_insn_pc,
        input  bpu_wb, bpu_wb_insn_pc, bpu_wb_taken, bpu_wb_tgt,
        output bpu_ready, bpu_pred_valid, bpu_pred_taken, bpu_pred_tgt
    );
endinterface

// File: rtl/ncpu32k_bpu_bimodal.sv
// Branch prediction unit: direct-mapped BTB with 2-bit saturating counters and a
// one-cycle registered lookup, or a plain always-not-taken predictor when STRATEGY=0.
module ncpu32k_bpu_bimodal #(
    parameter int AW       = 30,
    parameter int IDX_W    = 6,
    parameter int STRATEGY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    ncpu32k_bpu_bimodal_if.slave    bpu
);
    localparam int DEPTH = 1 << IDX_W;
    localparam int TW    = AW - IDX_W;

    generate
        if (STRATEGY == 0) begin : g_static
            logic r_ready;
            logic r_pred_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ready      <= 1'b0;
                    r_pred_valid <= 1'b0;
                end else begin
                    r_ready      <= 1'b1;
                    r_pred_valid <= bpu.bpu_req & r_ready;
                end
            end

            assign bpu.bpu_ready      = r_ready;
            assign bpu.bpu_pred_valid = r_pred_valid;
            assign bpu.bpu_pred_taken = 1'b0;
            assign bpu.bpu_pred_tgt   = '0;
        end else begin : g_bimodal
            typedef enum logic {S_INIT, S_RUN} state_t;

            state_t           r_state, w_state_next;
            logic [IDX_W-1:0] r_sweep, w_sweep_next;

            logic [DEPTH-1:0] r_valid, w_valid_next;
            logic [TW-1:0]    r_tag_mem [0:DEPTH-1];
            logic [AW-1:0]    r_tgt_mem [0:DEPTH-1];
            logic [1:0]       r_cnt_mem [0:DEPTH-1];

            logic             r_pred_valid;
            logic             r_pred_taken;
            logic [AW-1:0]    r_pred_tgt;

            logic             w_ready;
            logic             w_req_acc;
            logic             w_wb_acc;
            logic [IDX_W-1:0] w_lk_idx, w_wb_idx;
            logic [TW-1:0]    w_lk_tag, w_wb_tag;
            logic             w_lk_taken;
            logic             w_wb_hit;
            logic             w_alloc;
            logic [1:0]       w_wb_cnt, w_cnt_upd;

            assign w_ready   = (r_state == S_RUN);
            // A flush or reset in the same cycle wins over any lookup or training.
            assign w_req_acc = bpu.bpu_req & w_ready & ~bpu.bpu_flush & ~rst;
            assign w_wb_acc  = bpu.bpu_wb  & w_ready & ~bpu.bpu_flush & ~rst;

            assign w_lk_idx   = bpu.bpu_insn_pc[IDX_W-1:0];
            assign w_lk_tag   = bpu.bpu_insn_pc[AW-1:IDX_W];
            assign w_lk_taken = r_valid[w_lk_idx] & (r_tag_mem[w_lk_idx] == w_lk_tag)
                                & r_cnt_mem[w_lk_idx][1];

            assign w_wb_idx = bpu.bpu_wb_insn_pc[IDX_W-1:0];
            assign w_wb_tag = bpu.bpu_wb_insn_pc[AW-1:IDX_W];
            assign w_wb_hit = r_valid[w_wb_idx] & (r_tag_mem[w_wb_idx] == w_wb_tag);
            assign w_alloc  = w_wb_acc & ~w_wb_hit & bpu.bpu_wb_taken;

            always_comb begin
                w_wb_cnt  = r_cnt_mem[w_wb_idx];
                w_cnt_upd = w_wb_cnt;
                if (bpu.bpu_wb_taken) begin
                    if (w_wb_cnt != 2'b11) w_cnt_upd = w_wb_cnt + 2'b01;
                end else begin
                    if (w_wb_cnt != 2'b00) w_cnt_upd = w_wb_cnt - 2'b01;
                end
            end

            always_comb begin
                w_state_next = r_state;
                w_sweep_next = r_sweep;
                case (r_state)
                    S_INIT: begin
                        if (bpu.bpu_flush) begin
                            w_sweep_next = '0;
                        end else if (&r_sweep) begin
                            w_state_next = S_RUN;
                            w_sweep_next = '0;
                        end else begin
                            w_sweep_next = r_sweep + 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (bpu.bpu_flush) begin
                            w_state_next = S_INIT;
                            w_sweep_next = '0;
                        end
                    end
                    default: begin
                        w_state_next = S_INIT;
                        w_sweep_next = '0;
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state <= S_INIT;
                    r_sweep <= '0;
                end else begin
                    r_state <= w_state_next;
                    r_sweep <= w_sweep_next;
                end
            end

            // Sweep clear takes priority; allocation and sweep never coincide since
            // allocation needs RUN.
            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
                assign w_valid_next[gi] =
                    (r_state == S_INIT && r_sweep == IDX_W'(gi)) ? 1'b0 :
                    (w_alloc && w_wb_idx == IDX_W'(gi))          ? 1'b1 :
                                                                   r_valid[gi];
            end

            always_ff @(posedge clk) begin
                if (rst) r_valid <= '0;
                else     r_valid <= w_valid_next;
            end

            always_ff @(posedge clk) begin
                if (w_wb_acc) begin
                    if (w_wb_hit) begin
                        r_cnt_mem[w_wb_idx] <= w_cnt_upd;
                        if (bpu.bpu_wb_taken) r_tgt_mem[w_wb_idx] <= bpu.bpu_wb_tgt;
                    end else if (bpu.bpu_wb_taken) begin
                        r_tag_mem[w_wb_idx] <= w_wb_tag;
                        r_tgt_mem[w_wb_idx] <= bpu.bpu_wb_tgt;
                        r_cnt_mem[w_wb_idx] <= 2'b10;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pred_valid <= 1'b0;
                    r_pred_taken <= 1'b0;
                    r_pred_tgt   <= '0;
                end else begin
                    r_pred_valid <= w_req_acc;
                    r_pred_taken <= w_req_acc & w_lk_taken;
                    r_pred_tgt   <= (w_req_acc & w_lk_taken) ? r_tgt_mem[w_lk_idx] : '0;
                end
            end

            assign bpu.bpu_ready      = w_ready;
            assign bpu.bpu_pred_valid = r_pred_valid;
            assign bpu.bpu_pred_taken = r_pred_taken;
            assign bpu.bpu_pred_tgt   = r_pred_tgt;
        end
    endgenerate
endmodule

// File: doc/ncpu32k_bpu_bimodal.md
# ncpu32k_bpu_bimodal

Parametrised branch prediction unit for the ncpu32k fetch stage: a direct-mapped branch target buffer with 2-bit saturating counters (bimodal) behind a one-cycle registered lookup port, trained by a writeback port from the branch resolution stage. Replaces the fixed always-not-taken predictor; `STRATEGY=0` keeps that behaviour selectable. It sits between the PC generator (lookup) and the branch unit (update).

## Interface
- `AW`, 30, PC width in words (byte PC bits [31:2]).
- `IDX_W`, 6, log2 of table depth (DEPTH = 2^IDX_W); 1 <= IDX_W < AW.
- `STRATEGY`, 1, 0 = always-not-taken, 1 = bimodal BTB.
- `clk` in 1, sole clock; all state on rising edge.
- `rst` in 1, synchronous, active-high reset.
- `bpu_flush` in 1, invalidates the whole table (restarts sweep).
- `bpu_ready` out 1, high when lookups and updates are accepted.
- `bpu_req` in 1, lookup request, qualified by `bpu_ready`.
- `bpu_insn_pc` in AW, PC to predict.
- `bpu_pred_valid` out 1, prediction for the request accepted last cycle.
- `bpu_pred_taken` out 1, predicted taken.
- `bpu_pred_tgt` out AW, predicted target (word address).
- `bpu_wb` in 1, training strobe, qualified by `bpu_ready`.
- `bpu_wb_insn_pc` in AW, PC of resolved branch.
- `bpu_wb_taken` in 1, actual outcome.
- `bpu_wb_tgt` in AW, actual target.

## Operation
- Entry: `valid`, `tag` (AW-IDX_W bits), `tgt` (AW), `cnt` (2-bit). Index = pc[IDX_W-1:0], tag = pc[AW-1:IDX_W].
- States: INIT, RUN. `rst` -> INIT with sweep counter 0. INIT clears `valid` of entry[sweep] each cycle; after entry DEPTH-1 cleared -> RUN. `bpu_ready` = (state==RUN).
- `bpu_flush` in RUN -> INIT, sweep 0; in INIT restarts sweep at 0. A flush overrides a same-cycle `bpu_wb`/`bpu_req` (both dropped).
- In INIT, `bpu_req` and `bpu_wb` are ignored; no prediction issued.
- Lookup: hit = valid & tag match. taken = hit & cnt[1]; tgt = entry tgt if taken else 0.
- Update (`bpu_wb & bpu_ready`): hit -> cnt saturating +1 if taken, -1 if not (00 and 11 hold); if taken, tgt <= `bpu_wb_tgt`. Miss & taken -> allocate: valid=1, tag, tgt, cnt=2'b10. Miss & not taken -> no change.
- Same-cycle lookup and update to same index: lookup sees pre-update contents (no bypass).
- `STRATEGY=0`: no table, no INIT; `bpu_ready`=1 from first cycle after reset; `bpu_pred_valid` still follows `bpu_req`; taken=0, tgt=0; `bpu_wb` ignored.

## Timing
- Reset values: `bpu_ready`=0, `bpu_pred_valid`=0, `bpu_pred_taken`=0, `bpu_pred_tgt`=0.
- Lookup latency 1: request accepted in cycle N -> `bpu_pred_valid`/taken/tgt in N+1, valid for exactly one cycle; taken=0, tgt=0 whenever `bpu_pred_valid`=0.
- Back-to-back requests every cycle supported.
- Update written at end of accepting cycle; a lookup in N+1 observes it.
- INIT lasts exactly DEPTH cycles; first `bpu_ready`=1 in cycle DEPTH after `rst` deassert (cycle 0 = first non-reset cycle).
- `rst` asserted mid-operation: outputs return to reset values next edge; pending prediction discarded; full sweep repeats.

## Test plan
- Reset, IDX_W=6: `bpu_ready` low for 64 cycles then high; all outputs 0 during reset and INIT.
- Cold lookup pc=0x100 -> next cycle pred_valid=1, taken=0, tgt=0; then wb pc=0x100 taken tgt=0x200, lookup pc=0x100 -> taken=1, tgt=0x200.
- Counter saturation: 3 taken wb on pc=0x40 (cnt 10->11->11), 1 not-taken -> still taken (10), 2nd not-taken -> not taken (01), 2 more not-taken -> 00, 1 taken -> 01, predict not taken.
- Alias: train pc=0x005 taken tgt=0x80; lookup pc=0x045 (same index, different tag) -> taken=0; wb pc=0x045 taken tgt=0x90 replaces entry; pc=0x005 -> miss.
- Same-cycle lookup+wb on pc=0x10 (cold, taken) -> that lookup taken=0; lookup next cycle taken=1.
- Flush after training: `bpu_ready` low 64 cycles, wb in flush cycle dropped; afterwards trained PCs all predict not taken; STRATEGY=0 build: every request -> taken=0, tgt=0, ready=1 after reset.
